// File: rtl/host_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_responder_pkg
// Brief    : Shared encodings and constants for the host-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package host_mem_responder_pkg;

  // Channel handshake states, shared by the read and write channels.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_LAT  = 2'd1,
    CH_RESP = 2'd2,
    CH_ACK  = 2'd3
  } chan_state_t;

  localparam int          LAT_W            = 4;
  localparam logic [63:0] READY_ONE        = 64'd1;
  localparam logic [63:0] READY_ZERO       = 64'd0;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/host_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_responder_if
// Brief    : Wrapper host-memory bus (read and write beat channels).
// Revision : 1.0  initial release
// ============================================================================
interface host_mem_responder_if;
  logic        read_enable;
  logic [63:0] read_addr;
  logic        finish_read;
  logic        write_enable;
  logic [63:0] write_addr;
  logic [31:0] write_data;
  logic        finish_write;
  logic [63:0] read_ready;
  logic [31:0] read_data;
  logic [63:0] write_ready;

  modport master (
    output read_enable, read_addr, finish_read,
    output write_enable, write_addr, write_data, finish_write,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_enable, read_addr, finish_read,
    input  write_enable, write_addr, write_data, finish_write,
    output read_ready, read_data, write_ready
  );
endinterface
`default_nettype wire

// File: rtl/host_mem_chan.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_chan
// Brief    : Fixed-latency beat FSM: capture, count, respond, wait for ack.
// Revision : 1.0  initial release
// ============================================================================
module host_mem_chan
  import host_mem_responder_pkg::*;
#(
  parameter int LAT = 3   // legal range 1..15
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic finish,
  output logic capture,
  output logic resp
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT - 1);

  chan_state_t      r_state;
  chan_state_t      w_state_next;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CH_IDLE: begin
        if (enable) begin
          w_state_next = CH_LAT;
          w_cnt_next   = LAT_LOAD;
        end
      end
      CH_LAT: begin
        if (r_cnt == '0) w_state_next = CH_RESP;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      CH_RESP: w_state_next = CH_ACK;
      CH_ACK: begin
        // A finish pulse chains the next burst beat without passing through idle.
        if (finish) begin
          w_state_next = CH_LAT;
          w_cnt_next   = LAT_LOAD;
        end else if (!enable) begin
          w_state_next = CH_IDLE;
        end
      end
      default: w_state_next = CH_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    resp    = 1'b0;
    case (r_state)
      CH_IDLE: capture = enable;
      CH_ACK:  capture = finish;
      CH_RESP: resp    = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_responder
// Brief    : Word-addressed backing memory serving the wrapper host bus.
// Revision : 1.0  initial release
// ============================================================================
module host_mem_responder
  import host_mem_responder_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = 64'h0,
  parameter int          DEPTH_LOG2 = 14,
  parameter int          RD_LAT     = 3,
  parameter int          WR_LAT     = 2,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  host_mem_responder_if.slave   bus,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_widx,
  input  logic [31:0]           load_data,
  output logic [31:0]           rd_beats,
  output logic [31:0]           wr_beats,
  output logic                  addr_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [0:WORDS-1];

  logic                  w_rd_capture;
  logic                  w_rd_resp;
  logic                  w_wr_capture;
  logic                  w_wr_resp;

  logic [63:0]           r_rd_addr;
  logic [63:0]           r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_read_ready;
  logic                  r_write_ready;
  logic [31:0]           r_read_data;

  logic [63:0]           w_rd_off;
  logic [63:0]           w_wr_off;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic                  w_unused_off_bits;

  host_mem_chan #(.LAT(RD_LAT)) u_rd_chan (
    .clk     (clk),
    .reset   (reset),
    .enable  (bus.read_enable),
    .finish  (bus.finish_read),
    .capture (w_rd_capture),
    .resp    (w_rd_resp)
  );

  host_mem_chan #(.LAT(WR_LAT)) u_wr_chan (
    .clk     (clk),
    .reset   (reset),
    .enable  (bus.write_enable),
    .finish  (bus.finish_write),
    .capture (w_wr_capture),
    .resp    (w_wr_resp)
  );

  // Offsets wrap when addr < MEM_BASE, so the lower-bound test is explicit.
  assign w_rd_off          = r_rd_addr - MEM_BASE;
  assign w_wr_off          = r_wr_addr - MEM_BASE;
  assign w_rd_in_range     = (r_rd_addr >= MEM_BASE) && (w_rd_off[63:DEPTH_LOG2+2] == '0);
  assign w_wr_in_range     = (r_wr_addr >= MEM_BASE) && (w_wr_off[63:DEPTH_LOG2+2] == '0);
  assign w_rd_idx          = w_rd_off[DEPTH_LOG2+1:2];
  assign w_wr_idx          = w_wr_off[DEPTH_LOG2+1:2];
  assign w_unused_off_bits = ^{w_rd_off[1:0], w_wr_off[1:0]};

  assign bus.read_ready  = r_read_ready  ? READY_ONE : READY_ZERO;
  assign bus.write_ready = r_write_ready ? READY_ONE : READY_ZERO;
  assign bus.read_data   = r_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
      r_read_data   <= '0;
      rd_beats      <= '0;
      wr_beats      <= '0;
      addr_err      <= 1'b0;
    end else begin
      if (w_rd_capture) r_rd_addr <= bus.read_addr;
      if (w_wr_capture) begin
        r_wr_addr <= bus.write_addr;
        r_wr_data <= bus.write_data;
      end
      r_read_ready  <= w_rd_resp;
      r_write_ready <= w_wr_resp;
      if (w_rd_resp) begin
        r_read_data <= w_rd_in_range ? r_mem[w_rd_idx] : ERR_DATA;
        rd_beats    <= rd_beats + 32'd1;
      end
      if (w_wr_resp) wr_beats <= wr_beats + 32'd1;
      if ((w_rd_resp && !w_rd_in_range) || (w_wr_resp && !w_wr_in_range))
        addr_err <= 1'b1;
    end
  end

  // Contents survive reset; preload wins over a concurrent write commit.
  always_ff @(posedge clk) begin
    if (load_en)
      r_mem[load_widx] <= load_data;
    else if (w_wr_resp && w_wr_in_range)
      r_mem[w_wr_idx] <= r_wr_data;
  end

endmodule
`default_nettype wire

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Word-addressed backing-memory responder that sits directly downstream of the scratchpad wrapper's host-memory bus (read_enable/read_addr/finish_read, write_enable/write_addr/write_data/finish_write).
- Serves single and burst beats with a programmable fixed latency, returning read_ready/read_data and write_ready pulses in the wrapper's 64-bit "==1" format.
- Used as the host-memory stage in system simulation and as the FPGA-side memory stand-in; provides a preload port and beat/error counters.

Parameters:
- MEM_BASE, 64'h0, byte address mapped to word 0.
- DEPTH_LOG2, 14, log2 of the number of 32-bit words in the array.
- RD_LAT, 3, cycles from beat capture to the read_ready pulse; legal range 1..15.
- WR_LAT, 2, cycles from beat capture to the write_ready pulse; legal range 1..15.
- ERR_DATA, 32'hDEADBEEF, data returned for out-of-range reads.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- read_enable  in  1  read request level.
- read_addr  in  64  byte address of the current read beat.
- finish_read  in  1  one-cycle pulse: the next read beat is presented on read_addr.
- write_enable  in  1  write request level.
- write_addr  in  64  byte address of the current write beat.
- write_data  in  32  write beat data.
- finish_write  in  1  one-cycle pulse: the next write beat is presented.
- load_en  in  1  preload strobe; bench/host only.
- load_widx  in  DEPTH_LOG2  preload word index.
- load_data  in  32  preload data.
- read_ready  out  64  value 1 for one cycle when read_data is valid, otherwise 0.
- read_data  out  32  read beat data.
- write_ready  out  64  value 1 for one cycle when the write has committed, otherwise 0.
- rd_beats  out  32  count of completed read beats.
- wr_beats  out  32  count of completed write beats.
- addr_err  out  1  sticky flag: an out-of-range beat has occurred.

Behaviour:
- Reset (async): all outputs 0, both FSMs in IDLE, latency counters 0. Array contents are not cleared.
- Word index = (addr - MEM_BASE) >> 2.
  - Out of range when addr < MEM_BASE or index >= 2^DEPTH_LOG2.
  - Bits [1:0] of the offset are ignored.
- Read FSM states: R_IDLE, R_LAT, R_RESP, R_ACK.
  - R_IDLE: read_enable=1 -> capture read_addr, counter <= RD_LAT-1, go to R_LAT.
  - R_LAT: decrement the counter; at 0 go to R_RESP.
  - R_RESP: drive read_ready=1 and read_data = mem[idx] (ERR_DATA if out of range) for exactly this cycle; rd_beats += 1; go to R_ACK.
  - R_ACK, evaluated on the cycle after R_RESP, first match wins:
    - finish_read=1 -> capture read_addr as a new beat, go to R_LAT.
    - read_enable=0 -> go to R_IDLE.
    - otherwise stay in R_ACK.
  - A single-beat requester that drops read_enable one cycle after asserting it must still be served. The beat is captured on the enable, and the enable is not required to stay high.
  - Capture-to-ready latency is RD_LAT+1 cycles.
- Write FSM states: W_IDLE, W_LAT, W_RESP, W_ACK.
  - Mirrors the read FSM, using WR_LAT and finish_write.
  - Address and data are captured together at capture time.
  - Array write happens on the W_RESP edge, together with write_ready=1 and wr_beats += 1.
  - Out-of-range writes are dropped, set addr_err, and still return write_ready=1.
- Read and write FSMs run independently and concurrently.
  - On a same-cycle read (R_RESP) and write commit (W_RESP) to the same word, the read returns the old data.
- load_en has priority over a W_RESP commit in the same cycle; the write beat still acks.
- read_data holds its last value when read_ready=0.
- rd_beats and wr_beats wrap at 2^32.
- Deasserting read_enable while in R_LAT does not cancel the beat; the response is still issued.
- Reset mid-beat: the beat is aborted, no ready pulse is issued, and the partial write is not committed.

Decomposition:
- Shared package: wrapper bus state encodings, the READY_ONE = 64'd1 constant, and the ERR_DATA default.
- One natural sub-module: host_mem_chan, a parameterised latency/handshake FSM (capture, count, respond, ack) instantiated twice, once for read and once for write.
- Array and counters stay in the top.

Test Plan:
- Preload words 0..3 = 10,11,12,13. Single read at MEM_BASE+8, read_enable high for 1 cycle, RD_LAT=3 -> read_ready=1 exactly 4 cycles after capture, read_data=12, rd_beats=1.
- Burst read of 4 beats from MEM_BASE with a finish_read pulse after each ready -> data 10,11,12,13, four ready pulses each spaced RD_LAT+2 cycles apart, FSM returns to R_IDLE after read_enable drops.
- Write 0xA5 to MEM_BASE+4 with WR_LAT=2, then read the same address -> write_ready pulse 3 cycles after capture; read returns 0xA5; wr_beats=1.
- Read at MEM_BASE-4 and write at MEM_BASE+(2^DEPTH_LOG2)*4 -> read_data=0xDEADBEEF, write_ready still pulses, addr_err=1 and stays set, array unchanged.
- Read and write to the same word with R_RESP and W_RESP in the same cycle (old=7, new=9) -> read returns 7; a following read returns 9.
- Assert reset during R_LAT -> read_ready stays 0 and all outputs are 0; after release, a new request is served normally.
